// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display path.
package sseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t        SEG_OFF    = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam int unsigned NUM_DIGITS = 4;

endpackage : sseg_pkg

// File: rtl/free_run_counter.sv
// Free-running N-bit up counter with a combinational terminal-count flag.
module free_run_counter #(
    parameter int unsigned N = 18
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [N-1:0] o_q,
    output logic         o_wrap_c
);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + N'(1);
        end
    end

    assign o_q      = r_q;
    assign o_wrap_c = &r_q;

endmodule : free_run_counter

// File: rtl/sseg_mux_dimmer.sv
// Four-digit multiplexed seven-segment driver with per-digit blanking,
// PWM dimming and an end-of-frame strobe.
module sseg_mux_dimmer
    import sseg_pkg::*;
#(
    parameter int unsigned N  = 18,
    parameter int unsigned BW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [6:0]    in0_i,
    input  logic [6:0]    in1_i,
    input  logic [6:0]    in2_i,
    input  logic [6:0]    in3_i,
    input  logic [3:0]    dp_i,
    input  logic [3:0]    blank_i,
    input  logic [BW-1:0] bright_i,
    output logic [3:0]    an_o,
    output logic [6:0]    sseg_o,
    output logic          dp_o,
    output logic          frame_o
);

    if (N < BW + 3) begin : g_param_check
        $error("sseg_mux_dimmer: N must be >= BW+3");
    end

    logic [N-1:0]  w_q;
    logic          w_wrap;
    logic [1:0]    w_sel;
    logic [BW-1:0] w_frac;
    logic          w_frame_pt;
    logic          w_slot_pt;
    logic [3:0]    w_blank_nx;
    logic [BW-1:0] w_bright_nx;
    seg_t          w_seg_sel;
    logic          w_dp_sel;
    seg_t          w_seg_nx;
    logic          w_dp_nx;
    logic          w_on;
    logic [3:0]    w_an_nx;

    logic [3:0]    r_blank_l;
    logic [BW-1:0] r_bright_l;
    seg_t          r_seg_l;
    logic          r_dp_l;
    logic [3:0]    r_an;
    seg_t          r_sseg;
    logic          r_dp;
    logic          r_frame;

    free_run_counter #(.N(N)) u_cnt (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .o_q      (w_q),
        .o_wrap_c (w_wrap)
    );

    assign w_sel      = w_q[N-1:N-2];
    assign w_frac     = w_q[N-3:N-2-BW];
    assign w_frame_pt = (w_q == '0);
    assign w_slot_pt  = (w_q[N-3:0] == '0);

    // Digit pattern for the slot being entered.
    always_comb begin
        w_seg_sel = SEG_OFF;
        case (w_sel)
            2'd0:    w_seg_sel = in0_i;
            2'd1:    w_seg_sel = in1_i;
            2'd2:    w_seg_sel = in2_i;
            default: w_seg_sel = in3_i;
        endcase
    end

    assign w_dp_sel = dp_i[w_sel];

    // Post-edge latch values, so a capture cycle already drives the new data.
    assign w_blank_nx  = w_frame_pt ? blank_i  : r_blank_l;
    assign w_bright_nx = w_frame_pt ? bright_i : r_bright_l;
    assign w_seg_nx    = w_slot_pt  ? w_seg_sel : r_seg_l;
    assign w_dp_nx     = w_slot_pt  ? w_dp_sel  : r_dp_l;

    assign w_on    = !w_blank_nx[w_sel] && (w_frac < w_bright_nx);
    assign w_an_nx = w_on ? ~(4'b0001 << w_sel) : AN_OFF;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_blank_l  <= 4'hF;
            r_bright_l <= '0;
            r_seg_l    <= SEG_OFF;
            r_dp_l     <= 1'b1;
            r_an       <= AN_OFF;
            r_sseg     <= SEG_OFF;
            r_dp       <= 1'b1;
            r_frame    <= 1'b0;
        end else begin
            r_blank_l  <= w_blank_nx;
            r_bright_l <= w_bright_nx;
            r_seg_l    <= w_seg_nx;
            r_dp_l     <= w_dp_nx;
            r_an       <= w_an_nx;
            // Cathodes follow the anodes dark to avoid ghosting.
            r_sseg     <= w_on ? w_seg_nx : SEG_OFF;
            r_dp       <= w_on ? w_dp_nx  : 1'b1;
            r_frame    <= w_wrap;
        end
    end

    assign an_o    = r_an;
    assign sseg_o  = r_sseg;
    assign dp_o    = r_dp;
    assign frame_o = r_frame;

endmodule : sseg_mux_dimmer
